// File: rtl/vx_vector_wb_serializer.sv
// Vector writeback serializer: takes one assembled warp commit and replays it
// as one-thread-per-cycle writes on the VRF write port (masked threads are
// skipped), then pulses a completion for (wid, rd).
module vx_vector_wb_serializer #(
   parameter int NUM_THREADS = 4,
   parameter int VLEN        = 256,
   parameter int NW_BITS     = 2,
   parameter int NR_BITS     = 5,
   parameter int TID_BITS    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NW_BITS-1:0]            in_wid,
   input  logic [NR_BITS-1:0]            in_rd,
   input  logic [NUM_THREADS-1:0]        in_tmask,
   input  logic [NUM_THREADS*VLEN-1:0]   in_vd_data,
   output logic                          vrf_we,
   input  logic                          vrf_ready,
   output logic [NW_BITS-1:0]            vrf_wid,
   output logic [NR_BITS-1:0]            vrf_rd,
   output logic [TID_BITS-1:0]           vrf_tid,
   output logic [VLEN-1:0]               vrf_wdata,
   output logic                          done_valid,
   output logic [NW_BITS-1:0]            done_wid,
   output logic [NR_BITS-1:0]            done_rd
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                        state_reg;
   logic [NW_BITS-1:0]            wid_reg;
   logic [NR_BITS-1:0]            rd_reg;
   logic [NUM_THREADS-1:0]        pending_reg;
   logic [NUM_THREADS*VLEN-1:0]   data_reg;

   logic                          in_ready_reg;
   logic                          vrf_we_reg;
   logic [NW_BITS-1:0]            vrf_wid_reg;
   logic [NR_BITS-1:0]            vrf_rd_reg;
   logic [TID_BITS-1:0]           vrf_tid_reg;
   logic [VLEN-1:0]               vrf_wdata_reg;
   logic                          done_valid_reg;
   logic [NW_BITS-1:0]            done_wid_reg;
   logic [NR_BITS-1:0]            done_rd_reg;

   // Per-thread views of the incoming and captured data buses
   logic [VLEN-1:0] in_slice   [NUM_THREADS];
   logic [VLEN-1:0] data_slice [NUM_THREADS];

   for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_slice
      assign in_slice[gi]   = in_vd_data[gi*VLEN +: VLEN];
      assign data_slice[gi] = data_reg[gi*VLEN +: VLEN];
   end

   logic [NUM_THREADS-1:0] pending_clr;
   logic [NUM_THREADS-1:0] search_mask;
   logic [TID_BITS-1:0]    sel_tid;
   logic                   sel_any;

   // Pick the next thread: lowest set bit of the incoming mask when idle, or of
   // the pending mask with the currently presented thread removed when writing.
   // Precomputing it lets the VRF outputs be registered.
   always_comb begin
      pending_clr              = pending_reg;
      pending_clr[vrf_tid_reg] = 1'b0;
      search_mask = (state_reg == IDLE) ? in_tmask : pending_clr;
      sel_tid = '0;
      sel_any = 1'b0;
      for (int t = NUM_THREADS - 1; t >= 0; t--) begin
         if (search_mask[t]) begin
            sel_tid = TID_BITS'(t);
            sel_any = 1'b1;
         end
      end
   end

   // Commit FSM with all outputs registered; a stalled write simply holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         wid_reg        <= '0;
         rd_reg         <= '0;
         pending_reg    <= '0;
         data_reg       <= '0;
         in_ready_reg   <= 1'b1;
         vrf_we_reg     <= 1'b0;
         vrf_wid_reg    <= '0;
         vrf_rd_reg     <= '0;
         vrf_tid_reg    <= '0;
         vrf_wdata_reg  <= '0;
         done_valid_reg <= 1'b0;
         done_wid_reg   <= '0;
         done_rd_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  wid_reg      <= in_wid;
                  rd_reg       <= in_rd;
                  data_reg     <= in_vd_data;
                  pending_reg  <= in_tmask;
                  in_ready_reg <= 1'b0;
                  if (sel_any) begin
                     state_reg     <= WRITE;
                     vrf_we_reg    <= 1'b1;
                     vrf_wid_reg   <= in_wid;
                     vrf_rd_reg    <= in_rd;
                     vrf_tid_reg   <= sel_tid;
                     vrf_wdata_reg <= in_slice[sel_tid];
                  end else begin
                     state_reg      <= DONE;
                     done_valid_reg <= 1'b1;
                     done_wid_reg   <= in_wid;
                     done_rd_reg    <= in_rd;
                  end
               end
            end
            WRITE: begin
               if (vrf_ready) begin
                  pending_reg <= pending_clr;
                  if (sel_any) begin
                     vrf_tid_reg   <= sel_tid;
                     vrf_wdata_reg <= data_slice[sel_tid];
                  end else begin
                     state_reg      <= DONE;
                     vrf_we_reg     <= 1'b0;
                     vrf_wid_reg    <= '0;
                     vrf_rd_reg     <= '0;
                     vrf_tid_reg    <= '0;
                     vrf_wdata_reg  <= '0;
                     done_valid_reg <= 1'b1;
                     done_wid_reg   <= wid_reg;
                     done_rd_reg    <= rd_reg;
                  end
               end
            end
            DONE: begin
               state_reg      <= IDLE;
               in_ready_reg   <= 1'b1;
               done_valid_reg <= 1'b0;
               done_wid_reg   <= '0;
               done_rd_reg    <= '0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_reg;
   assign vrf_we     = vrf_we_reg;
   assign vrf_wid    = vrf_wid_reg;
   assign vrf_rd     = vrf_rd_reg;
   assign vrf_tid    = vrf_tid_reg;
   assign vrf_wdata  = vrf_wdata_reg;
   assign done_valid = done_valid_reg;
   assign done_wid   = done_wid_reg;
   assign done_rd    = done_rd_reg;

endmodule

// File: tb/tb_vx_vector_wb_serializer.sv
// Scoreboard bench for vx_vector_wb_serializer: each commit pushes its expected
// writes (with expected cycle) and completion; a negedge monitor pops them.
module tb_vx_vector_wb_serializer;

   localparam int NUM_THREADS = 4;
   localparam int VLEN        = 256;
   localparam int NW_BITS     = 2;
   localparam int NR_BITS     = 5;
   localparam int TID_BITS    = 2;

   logic                          clk = 1'b0;
   logic                          reset;
   logic                          in_valid;
   logic                          in_ready;
   logic [NW_BITS-1:0]            in_wid;
   logic [NR_BITS-1:0]            in_rd;
   logic [NUM_THREADS-1:0]        in_tmask;
   logic [NUM_THREADS*VLEN-1:0]   in_vd_data;
   logic                          vrf_we;
   logic                          vrf_ready;
   logic [NW_BITS-1:0]            vrf_wid;
   logic [NR_BITS-1:0]            vrf_rd;
   logic [TID_BITS-1:0]           vrf_tid;
   logic [VLEN-1:0]               vrf_wdata;
   logic                          done_valid;
   logic [NW_BITS-1:0]            done_wid;
   logic [NR_BITS-1:0]            done_rd;

   vx_vector_wb_serializer #(
      .NUM_THREADS(NUM_THREADS), .VLEN(VLEN), .NW_BITS(NW_BITS),
      .NR_BITS(NR_BITS), .TID_BITS(TID_BITS)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_rd(in_rd),
      .in_tmask(in_tmask), .in_vd_data(in_vd_data),
      .vrf_we(vrf_we), .vrf_ready(vrf_ready), .vrf_wid(vrf_wid), .vrf_rd(vrf_rd),
      .vrf_tid(vrf_tid), .vrf_wdata(vrf_wdata),
      .done_valid(done_valid), .done_wid(done_wid), .done_rd(done_rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                 tid;
      logic [NW_BITS-1:0] wid;
      logic [NR_BITS-1:0] rd;
      logic [VLEN-1:0]    data;
      int                 cycle;
   } wr_t;

   typedef struct {
      logic [NW_BITS-1:0] wid;
      logic [NR_BITS-1:0] rd;
      int                 cycle;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  cur_cycle = 0;

   task automatic check_eq(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cur_cycle);
      end
   endtask

   // Monitor: every presented write must match the scoreboard head; a write is
   // consumed when vrf_ready accepts it. Idle outputs must be zero.
   always @(negedge clk) begin
      if (!reset) begin
         if (vrf_we) begin
            if (wq.size() == 0) begin
               check_eq("unexpected_we", 1, 0);
            end else begin
               check_eq("vrf_tid", vrf_tid, wq[0].tid);
               check_eq("vrf_wdata", vrf_wdata, wq[0].data);
               check_eq("vrf_wid", vrf_wid, wq[0].wid);
               check_eq("vrf_rd", vrf_rd, wq[0].rd);
               if (vrf_ready) begin
                  check_eq("we_cycle", cur_cycle, wq[0].cycle);
                  void'(wq.pop_front());
               end
            end
         end else begin
            check_eq("vrf_idle_zero", |{vrf_tid, vrf_wid, vrf_rd, vrf_wdata}, 0);
         end
         if (done_valid) begin
            if (dq.size() == 0) begin
               check_eq("unexpected_done", 1, 0);
            end else begin
               check_eq("done_wid", done_wid, dq[0].wid);
               check_eq("done_rd", done_rd, dq[0].rd);
               check_eq("done_at", cur_cycle, dq[0].cycle);
               void'(dq.pop_front());
            end
         end else begin
            check_eq("done_idle_zero", |{done_wid, done_rd}, 0);
         end
      end
   end

   // Drive a commit (called at posedge+1) and push its expected writes/done.
   // stall bit c means vrf_ready=0 in cycle c after the accept edge.
   task automatic drive_commit(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] rd,
                               input logic [NUM_THREADS-1:0] tmask, input logic [31:0] base,
                               input logic [63:0] stall);
      logic [NUM_THREADS*VLEN-1:0] data;
      wr_t w;
      dn_t d;
      int  c;
      for (int t = 0; t < NUM_THREADS; t++)
         data[t*VLEN +: VLEN] = {(VLEN/32){base + 32'(t)}};
      c = 1;
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (tmask[t]) begin
            while (stall[c]) c++;
            w.tid = t; w.wid = wid; w.rd = rd;
            w.data = data[t*VLEN +: VLEN]; w.cycle = c;
            wq.push_back(w);
            c++;
         end
      end
      d.wid = wid; d.rd = rd; d.cycle = c;
      dq.push_back(d);
      in_valid = 1'b1; in_wid = wid; in_rd = rd; in_tmask = tmask; in_vd_data = data;
      vrf_ready = 1'b1;
      cur_cycle = 0;
   endtask

   task automatic run_commit(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] rd,
                             input logic [NUM_THREADS-1:0] tmask, input logic [31:0] base,
                             input logic [63:0] stall, input bit late_change, input int exp_done);
      int done_c;
      drive_commit(wid, rd, tmask, base, stall);
      @(posedge clk); #1;
      if (late_change) begin
         in_wid = ~wid; in_rd = ~rd; in_vd_data = ~in_vd_data;
      end else begin
         in_valid = 1'b0;
      end
      done_c = 0;
      for (int c = 1; c < 64; c++) begin
         if (done_c != 0) in_valid = 1'b0;
         vrf_ready = !stall[c];
         cur_cycle = c;
         @(negedge clk);
         if (done_valid && done_c == 0) done_c = c;
         check_eq("in_ready", in_ready, (done_c != 0 && c == done_c + 1));
         if (done_c != 0 && c == done_c + 1) break;
         @(posedge clk); #1;
      end
      check_eq("done_cycle", done_c, exp_done);
      check_eq("writes_left", wq.size(), 0);
      check_eq("dones_left", dq.size(), 0);
      wq.delete(); dq.delete();
      @(posedge clk); #1;
      in_valid = 1'b0; vrf_ready = 1'b1; cur_cycle = 0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_rd = '0; in_tmask = '0;
      in_vd_data = '0; vrf_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_vrf_we", vrf_we, 0);
      check_eq("rst_done_valid", done_valid, 0);
      @(posedge clk); #1;

      run_commit(2'd1, 5'd5,  4'b1111, 32'h1000_0000, 64'h0,  1'b0, 5);   // full mask
      run_commit(2'd2, 5'd17, 4'b1010, 32'h2000_0000, 64'h0,  1'b0, 3);   // sparse
      run_commit(2'd3, 5'd31, 4'b0000, 32'h3000_0000, 64'h0,  1'b0, 1);   // empty
      run_commit(2'd0, 5'd9,  4'b1111, 32'h1000_0000, 64'h6E, 1'b0, 10);  // backpressure
      run_commit(2'd2, 5'd12, 4'b0101, 32'h5000_0000, 64'h0,  1'b1, 3);   // late input change

      // Reset mid-commit: accepted at edge 0, reset high during cycle 2
      drive_commit(2'd1, 5'd7, 4'b1111, 32'h6000_0000, 64'h0);
      @(posedge clk); #1; in_valid = 1'b0; cur_cycle = 1;
      @(posedge clk); #1; reset = 1'b1; cur_cycle = 2;
      @(posedge clk); #1; reset = 1'b0; cur_cycle = 3;
      wq.delete(); dq.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_mid_we", vrf_we, 0);
         check_eq("rst_mid_done", done_valid, 0);
         check_eq("rst_mid_ready", in_ready, 1);
         @(posedge clk); #1;
      end
      run_commit(2'd3, 5'd20, 4'b0100, 32'h7000_0000, 64'h0, 1'b0, 2);

      // A few random masks with random stalls; expected done = 1 + k + stalls
      for (int i = 0; i < 6; i++) begin
         logic [NUM_THREADS-1:0] m;
         logic [63:0]            s;
         int                     k, e, c;
         m = NUM_THREADS'($urandom);
         s = 64'($urandom_range(0, 32'hFFFF)) & 64'hFFFE;
         k = $countones(m);
         c = 1; e = 0;
         while (e < k) begin
            if (!s[c]) e++;
            c++;
         end
         run_commit(NW_BITS'($urandom), NR_BITS'($urandom), m, $urandom, s, 1'b0, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
